// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Main control FSM for the multicycle datapath. It sequences
// fetch / decode / execute / memory / writeback from the instruction opcode,
// drives every datapath enable and mux select, and produces aluOp for the
// ALU control decoder. It handshakes with instruction/data memory through
// memReady and stops in a sticky FAULT state on an illegal opcode or a
// memory timeout.
//
// Parameters:
//   MEM_TIMEOUT  max cycles a memory state waits for memReady (0 = no limit)
//   CNT_W        wait counter width, MEM_TIMEOUT must be < 2**CNT_W
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   opcode       instruction[31:26] from the IR, used in DECODE / MEMADR
//   zero         ALU zero flag (qualified in the datapath by pcWriteCond)
//   memReady     memory finished the current read or write this cycle
//   memRead, memWrite, iorD            memory request / address select
//   irWrite, pcWrite, pcWriteCond      IR and PC load enables
//   pcSource     00 ALU, 01 ALUOut, 10 jump target
//   aluOp        00 add, 01 subtract, 10 decode by funct
//   aluSrcA      0 PC, 1 register A
//   aluSrcB      00 B, 01 4, 10 sext imm, 11 sext imm << 2
//   regWrite, regDst, memToReg         register file writeback controls
//   fault        sticky fault indicator
//   illegalOp    sticky, fault was caused by an illegal opcode
//   state        current state encoding (debug / verification)
// -----------------------------------------------------------------------------
module multicycle_control #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       memReady,
    output logic       memRead,
    output logic       memWrite,
    output logic       iorD,
    output logic       irWrite,
    output logic       pcWrite,
    output logic       pcWriteCond,
    output logic [1:0] pcSource,
    output logic [1:0] aluOp,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic       regWrite,
    output logic       regDst,
    output logic       memToReg,
    output logic       fault,
    output logic       illegalOp,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_FAULT  = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state_q;
    logic [CNT_W-1:0] wait_cnt;
    logic             mem_state;
    logic             waiting;
    logic             timeout_hit;

    // The zero flag is consumed by the datapath together with pcWriteCond;
    // the FSM only passes through it by name.
    logic unused_zero;
    assign unused_zero = zero;

    // A "waiting cycle" is a cycle in a memory-handshake state without
    // memReady. The timeout fires on the waiting cycle whose count is
    // MEM_TIMEOUT-1; a memReady on that same cycle is not waiting, so it wins.
    always_comb begin
        mem_state   = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                      (state_q == S_MEMWR);
        waiting     = mem_state && !memReady;
        timeout_hit = (MEM_TIMEOUT != 0) && waiting && (wait_cnt == CNT_LAST);
    end

    // -------------------------------------------------------------------------
    // State register, wait counter and sticky fault flags
    // -------------------------------------------------------------------------
    // NOTE: every register below is assigned with <= so all of them update
    // from the same pre-edge values; blocking assignments here would let the
    // order of statements change the behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            wait_cnt  <= '0;
            fault     <= 1'b0;
            illegalOp <= 1'b0;
        end else begin
            // Count only while still waiting in the same memory state; any
            // transition (entry to FETCH/MEMRD/MEMWR included) or memReady
            // restarts the count from zero.
            if (waiting && !timeout_hit) begin
                if (wait_cnt != '1) begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end else begin
                wait_cnt <= '0;
            end

            if (timeout_hit) begin
                state_q <= S_FAULT;
                fault   <= 1'b1;
            end else begin
                case (state_q)
                    S_FETCH: begin
                        if (memReady) state_q <= S_DECODE;
                    end
                    S_DECODE: begin
                        case (opcode)
                            OP_RTYPE:      state_q <= S_EXEC;
                            OP_LW, OP_SW:  state_q <= S_MEMADR;
                            OP_BEQ:        state_q <= S_BRANCH;
                            OP_J:          state_q <= S_JUMP;
                            OP_ADDI:       state_q <= S_ADDIEX;
                            default: begin
                                state_q   <= S_FAULT;
                                fault     <= 1'b1;
                                illegalOp <= 1'b1;
                            end
                        endcase
                    end
                    // The IR holds the opcode stable, so it is only lw or sw here.
                    S_MEMADR: state_q <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
                    S_MEMRD: begin
                        if (memReady) state_q <= S_MEMWB;
                    end
                    S_MEMWB:  state_q <= S_FETCH;
                    S_MEMWR: begin
                        if (memReady) state_q <= S_FETCH;
                    end
                    S_EXEC:   state_q <= S_ALUWB;
                    S_ALUWB:  state_q <= S_FETCH;
                    S_BRANCH: state_q <= S_FETCH;
                    S_JUMP:   state_q <= S_FETCH;
                    S_ADDIEX: state_q <= S_ADDIWB;
                    S_ADDIWB: state_q <= S_FETCH;
                    S_FAULT:  state_q <= S_FAULT;
                    default: begin
                        state_q <= S_FAULT;
                        fault   <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign state = state_q;

    // -------------------------------------------------------------------------
    // Moore output decode
    // -------------------------------------------------------------------------
    // NOTE: every output gets a default at the top of the block, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        memRead     = 1'b0;
        memWrite    = 1'b0;
        iorD        = 1'b0;
        irWrite     = 1'b0;
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        pcSource    = 2'b00;
        aluOp       = 2'b00;
        aluSrcA     = 1'b0;
        aluSrcB     = 2'b00;
        regWrite    = 1'b0;
        regDst      = 1'b0;
        memToReg    = 1'b0;

        case (state_q)
            S_FETCH: begin
                memRead = 1'b1;
                aluSrcB = 2'b01;
                // IR and PC load exactly when the fetch completes.
                irWrite = memReady;
                pcWrite = memReady;
            end
            S_DECODE: begin
                aluSrcB = 2'b11;
            end
            S_MEMADR: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
            end
            S_MEMRD: begin
                memRead = 1'b1;
                iorD    = 1'b1;
            end
            S_MEMWB: begin
                regWrite = 1'b1;
                memToReg = 1'b1;
            end
            S_MEMWR: begin
                memWrite = 1'b1;
                iorD     = 1'b1;
            end
            S_EXEC: begin
                aluSrcA = 1'b1;
                aluOp   = 2'b10;
            end
            S_ALUWB: begin
                regWrite = 1'b1;
                regDst   = 1'b1;
            end
            S_BRANCH: begin
                aluSrcA     = 1'b1;
                aluOp       = 2'b01;
                pcWriteCond = 1'b1;
                pcSource    = 2'b01;
            end
            S_JUMP: begin
                pcWrite  = 1'b1;
                pcSource = 2'b10;
            end
            S_ADDIEX: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
            end
            S_ADDIWB: begin
                regWrite = 1'b1;
            end
            default: ; // FAULT and unused encodings: everything stays 0
        endcase

        // NOTE: the state register resets to FETCH, whose decode requests a
        // read; gating the enables with rst_n keeps every write and request
        // off for as long as reset is held, including mid-instruction aborts.
        if (!rst_n) begin
            memRead     = 1'b0;
            memWrite    = 1'b0;
            irWrite     = 1'b0;
            pcWrite     = 1'b0;
            pcWriteCond = 1'b0;
            regWrite    = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
//
// Directed bench for multicycle_control. Two instances share the stimulus:
// dut uses the default memory timeout, dut_to uses MEM_TIMEOUT=4 for the
// timeout cases. Inputs change and outputs are sampled 1 time unit after the
// rising edge.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       zero;
    logic       memReady;

    logic       memRead, memWrite, iorD, irWrite, pcWrite, pcWriteCond;
    logic [1:0] pcSource, aluOp, aluSrcB;
    logic       aluSrcA, regWrite, regDst, memToReg, fault, illegalOp;
    logic [3:0] state;

    logic       t_memRead, t_memWrite, t_iorD, t_irWrite, t_pcWrite, t_pcWriteCond;
    logic [1:0] t_pcSource, t_aluOp, t_aluSrcB;
    logic       t_aluSrcA, t_regWrite, t_regDst, t_memToReg, t_fault, t_illegalOp;
    logic [3:0] t_state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .memReady(memReady),
        .memRead(memRead), .memWrite(memWrite), .iorD(iorD), .irWrite(irWrite),
        .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .pcSource(pcSource),
        .aluOp(aluOp), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .regWrite(regWrite),
        .regDst(regDst), .memToReg(memToReg), .fault(fault), .illegalOp(illegalOp),
        .state(state)
    );

    multicycle_control #(.MEM_TIMEOUT(4), .CNT_W(8)) dut_to (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .memReady(memReady),
        .memRead(t_memRead), .memWrite(t_memWrite), .iorD(t_iorD), .irWrite(t_irWrite),
        .pcWrite(t_pcWrite), .pcWriteCond(t_pcWriteCond), .pcSource(t_pcSource),
        .aluOp(t_aluOp), .aluSrcA(t_aluSrcA), .aluSrcB(t_aluSrcB), .regWrite(t_regWrite),
        .regDst(t_regDst), .memToReg(t_memToReg), .fault(t_fault), .illegalOp(t_illegalOp),
        .state(t_state)
    );

    // Enables packed as {memRead, memWrite, irWrite, pcWrite, pcWriteCond, regWrite}
    wire [5:0] enables = {memRead, memWrite, irWrite, pcWrite, pcWriteCond, regWrite};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        opcode   = 6'b000000;
        zero     = 1'b0;
        memReady = 1'b1;

        // ---- reset: 3 cycles low, memReady high ----
        tick(); tick(); tick();
        check("rst_enables", 32'(enables), 32'h0);
        check("rst_state", 32'(state), 32'd0);
        check("rst_fault", 32'({fault, illegalOp}), 32'h0);
        rst_n = 1'b1;
        #1;
        check("fetch_rd_ir_pc", 32'({memRead, irWrite, pcWrite, iorD}), 32'b1110);
        check("fetch_alu", 32'({aluSrcA, aluSrcB, aluOp, pcSource}), 32'b0_01_00_00);

        // ---- R-type: 0,1,6,7,0 ----
        tick();
        check("r_decode", 32'(state), 32'd1);
        check("r_decode_alu", 32'({aluSrcA, aluSrcB, aluOp}), 32'b0_11_00);
        tick();
        check("r_exec", 32'(state), 32'd6);
        check("r_exec_alu", 32'({aluSrcA, aluSrcB, aluOp, regWrite}), 32'b1_00_10_0);
        tick();
        check("r_aluwb", 32'(state), 32'd7);
        check("r_aluwb_wr", 32'({regWrite, regDst, memToReg}), 32'b110);
        tick();
        check("r_back", 32'(state), 32'd0);
        check("r_back_nowr", 32'(regWrite), 32'd0);

        // ---- lw with 3 waiting cycles in MEMRD ----
        opcode = 6'b100011;
        tick();
        check("lw_decode", 32'(state), 32'd1);
        tick();
        check("lw_memadr", 32'({state, aluSrcA, aluSrcB}), {4'd2, 1'b1, 2'b10});
        memReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("lw_memrd_wait%0d", i), 32'({state, memRead, iorD}), {4'd3, 2'b11});
        end
        memReady = 1'b1;
        tick();
        check("lw_memwb", 32'({state, regWrite, memToReg, regDst}), {4'd4, 3'b110});
        check("lw_memwb_to", 32'(t_state), 32'd4);
        tick();
        check("lw_back", 32'(state), 32'd0);

        // ---- beq: 0,1,8,0 ----
        opcode = 6'b000100;
        tick();
        tick();
        check("beq_state", 32'(state), 32'd8);
        check("beq_ctl", 32'({aluOp, pcWriteCond, pcSource, pcWrite, aluSrcA}), 32'b01_1_01_0_1);
        tick();
        check("beq_back", 32'(state), 32'd0);

        // ---- j: 0,1,9,0 ----
        opcode = 6'b000010;
        tick();
        tick();
        check("j_ctl", 32'({state, pcWrite, pcSource}), {4'd9, 1'b1, 2'b10});
        tick();
        check("j_back", 32'(state), 32'd0);

        // ---- addi: 0,1,10,11,0 ----
        opcode = 6'b001000;
        tick();
        tick();
        check("addi_ex", 32'({state, aluSrcA, aluSrcB, aluOp}), {4'd10, 1'b1, 2'b10, 2'b00});
        tick();
        check("addi_wb", 32'({state, regWrite, regDst, memToReg}), {4'd11, 3'b100});
        tick();
        check("addi_back", 32'(state), 32'd0);

        // ---- sw, then reset asserted in MEMWR ----
        opcode = 6'b101011;
        tick();
        tick();
        tick();
        check("sw_memwr", 32'({state, memWrite, iorD}), {4'd5, 2'b11});
        rst_n = 1'b0;
        #1;
        check("sw_abort_en", 32'(enables), 32'h0);
        check("sw_abort_state", 32'(state), 32'd0);
        tick();
        rst_n = 1'b1;

        // ---- illegal opcode, then 10 cycles of memReady toggling ----
        opcode = 6'b111111;
        tick();
        tick();
        check("ill_state", 32'({state, fault, illegalOp}), {4'd12, 2'b11});
        for (int i = 0; i < 10; i++) begin
            memReady = i[0];
            #1;
            check($sformatf("ill_hold%0d", i), 32'({state, enables}), {4'd12, 6'b0});
            tick();
        end
        rst_n = 1'b0;
        #1;
        check("ill_reset", 32'({state, fault, illegalOp, enables}), 32'h0);

        // ---- memory timeout in FETCH, MEM_TIMEOUT=4 ----
        memReady = 1'b0;
        opcode   = 6'b000000;
        tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        check("to_before", 32'({t_state, t_fault}), 32'h0);
        tick();
        check("to_fault", 32'({t_state, t_fault, t_illegalOp}), {4'd12, 2'b10});
        check("to_default_dut", 32'({state, fault}), 32'h0);

        // ---- rerun: memReady on the 4th waiting cycle wins ----
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        memReady = 1'b1;
        tick();
        check("to_ready_wins", 32'({t_state, t_fault, t_illegalOp}), {4'd1, 2'b00});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle datapath; the producer side of the aluOp interface that the ALU control decoder consumes.
- Sequences fetch/decode/execute/memory/writeback from the instruction opcode.
- Drives all datapath enables and mux selects, including aluOp[1:0]: 00 add, 01 subtract, 10 decode-by-funct.
- Handshakes with instruction/data memory via memReady; faults on illegal opcode or memory timeout.

Parameters:
- MEM_TIMEOUT, 255: max cycles a memory state waits for memReady before FAULT. 0 disables the timeout.
- CNT_W, 8: width of the wait counter. Must satisfy MEM_TIMEOUT < 2**CNT_W.

Ports:
- clk  input  1  Single clock; all state changes on its rising edge.
- rst_n  input  1  Reset, asynchronous assert, active-low.
- opcode  input  6  Instruction[31:26] from the instruction register; sampled in DECODE.
- zero  input  1  ALU zero flag. Consumed by the datapath with pcWriteCond, not by the FSM.
- memReady  input  1  Memory completed the current read or write this cycle.
- memRead  output  1  Memory read request.
- memWrite  output  1  Memory write request.
- iorD  output  1  Memory address select: 0 = PC, 1 = ALUOut.
- irWrite  output  1  Load the instruction register.
- pcWrite  output  1  Unconditional PC load.
- pcWriteCond  output  1  PC load qualified by zero (beq).
- pcSource  output  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
- aluOp  output  2  To the ALU control decoder.
- aluSrcA  output  1  ALU A select: 0 = PC, 1 = register A.
- aluSrcB  output  2  ALU B select: 00 = B, 01 = 4, 10 = signext imm, 11 = signext imm << 2.
- regWrite  output  1  Register file write enable.
- regDst  output  1  Destination register: 0 = rt, 1 = rd.
- memToReg  output  1  Writeback data: 0 = ALUOut, 1 = MDR.
- fault  output  1  Sticky fault indicator.
- illegalOp  output  1  Sticky; set when the fault cause is an illegal opcode.
- state  output  4  Current state encoding, for debug and verification.

Behaviour:
- Moore outputs, decoded from the state register. Exceptions: memReady gates irWrite/pcWrite in FETCH and regWrite in MEMWB is not gated. Unlisted enables = 0; unlisted selects = 0.
- Reset (rst_n=0, asynchronous): state = FETCH (0), wait counter = 0, fault = 0, illegalOp = 0.
  - While rst_n = 0, every enable (memRead, memWrite, irWrite, pcWrite, pcWriteCond, regWrite) is forced to 0.
  - Reset mid-operation aborts the instruction; no partial write may occur after rst_n falls.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11, FAULT 12.
- FETCH: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSource=00.
  - irWrite and pcWrite = memReady.
  - memReady=1 -> DECODE; otherwise stay.
- DECODE: aluSrcA=0, aluSrcB=11, aluOp=00 (branch target precompute). Next state by opcode:
  - 000000 -> EXEC
  - 100011 (lw), 101011 (sw) -> MEMADR
  - 000100 (beq) -> BRANCH
  - 000010 (j) -> JUMP
  - 001000 (addi) -> ADDIEX
  - any other opcode -> FAULT, with illegalOp set.
- MEMADR: aluSrcA=1, aluSrcB=10, aluOp=00. lw -> MEMRD; sw -> MEMWR (opcode held stable by the IR).
- MEMRD: memRead=1, iorD=1. memReady -> MEMWB.
- MEMWB: regWrite=1, memToReg=1, regDst=0 -> FETCH.
- MEMWR: memWrite=1, iorD=1. memReady -> FETCH.
- EXEC: aluSrcA=1, aluSrcB=00, aluOp=10 -> ALUWB.
- ALUWB: regWrite=1, regDst=1, memToReg=0 -> FETCH.
- BRANCH: aluSrcA=1, aluSrcB=00, aluOp=01, pcWriteCond=1, pcSource=01 -> FETCH.
- JUMP: pcWrite=1, pcSource=10 -> FETCH.
- ADDIEX: aluSrcA=1, aluSrcB=10, aluOp=00 -> ADDIWB.
- ADDIWB: regWrite=1, regDst=0, memToReg=0 -> FETCH.
- Wait counter:
  - Clears on entry to each of FETCH, MEMRD, MEMWR and when memReady=1.
  - Increments on each waiting cycle in those states (saturating).
  - With MEM_TIMEOUT>0, a waiting cycle where the counter equals MEM_TIMEOUT-1 and memReady=0 -> FAULT, illegalOp=0.
  - memReady arriving on that same cycle wins: normal advance, no fault.
- FAULT: all enables 0, fault=1. Terminal until reset.
- Latencies at zero memory wait: R-type/addi 4 cycles, lw 5, sw 4, beq 3, j 3.

Test Plan:
- Reset with rst_n low for 3 cycles, memReady=1 -> all enables 0 and state=0. First edge after release: memRead=1, irWrite=1, pcWrite=1, then state=1.
- R-type (opcode 000000), memReady tied 1 -> state sequence 0,1,6,7,0; aluOp=10 in EXEC; regWrite=1 with regDst=1 in ALUWB only.
- lw (100011), memReady low for 3 cycles in MEMRD -> state holds 3 for 3 cycles with memRead=1, iorD=1. Then 4, then 0; regWrite=1 with memToReg=1 in MEMWB.
- beq (000100) -> sequence 0,1,8,0; BRANCH shows aluOp=01, pcWriteCond=1, pcSource=01, and pcWrite stays 0.
- Illegal opcode 111111 in DECODE -> state=12, fault=1, illegalOp=1. All enables stay 0 with memReady toggling for 10 cycles until rst_n=0.
- MEM_TIMEOUT=4, memReady held 0 in FETCH -> state=12 after 4 waiting cycles, fault=1, illegalOp=0. Rerun with memReady=1 on the 4th waiting cycle -> DECODE, no fault.
